// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier arbiter slice.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } arb_state_t;

  // Cycles from the multiplier sampling start to its finish pulse, measured from accept.
  function automatic int unsigned mul_latency(input int unsigned n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after `last`, modulo R.
module rr_arbiter #(
  parameter int unsigned R  = 4,
  parameter int unsigned RW = $clog2(R)
) (
  input  logic [R-1:0]  req,
  input  logic [RW-1:0] last,
  input  logic          en,
  output logic [R-1:0]  grant,
  output logic [RW-1:0] grant_idx
);

  logic [RW-1:0] idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i <= R; i++) begin
      idx = RW'((32'(last) + i) % R);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin scheduler sharing one Booth multiplier between R requesters,
// with a watchdog that returns an error response if the multiplier never finishes.
module booth_mult_arbiter
  import booth_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned R       = 4,
  parameter int unsigned RW      = $clog2(R),
  parameter int unsigned TIMEOUT = mul_latency(N) + 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [R-1:0]   i_req_valid,
  output logic [R-1:0]   o_req_ready,
  input  logic [R*N-1:0] i_req_a,
  input  logic [R*N-1:0] i_req_b,
  output logic [R-1:0]   o_rsp_valid,
  input  logic [R-1:0]   i_rsp_ready,
  output logic [2*N-1:0] o_rsp_result,
  output logic           o_rsp_error,
  output logic           o_mul_start,
  output logic [N-1:0]   o_mul_multiplier,
  output logic [N-1:0]   o_mul_multiplicand,
  input  logic [2*N-1:0] i_mul_result,
  input  logic           i_mul_finish,
  output logic           o_busy
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  arb_state_t     state;
  logic [RW-1:0]  last;
  logic [RW-1:0]  gidx;
  logic [RW-1:0]  grant_idx;
  logic [R-1:0]   grant;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [2*N-1:0] result;
  logic           error;
  logic [CW-1:0]  cnt;
  logic           arb_en;

  // Reset gates the accept pulse so ready is 0 while reset is held.
  assign arb_en = (state == IDLE) && i_rst_n;

  rr_arbiter #(
    .R  (R),
    .RW (RW)
  ) u_rr (
    .req       (i_req_valid),
    .last      (last),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      last   <= RW'(R - 1);
      gidx   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      error  <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|grant) begin
            op_a  <= i_req_a[grant_idx*N +: N];
            op_b  <= i_req_b[grant_idx*N +: N];
            gidx  <= grant_idx;
            state <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (i_mul_finish) begin
            result <= i_mul_result;
            error  <= 1'b0;
            state  <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            result <= '0;
            error  <= 1'b1;
            state  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (i_rsp_ready[gidx]) begin
            last  <= gidx;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    if (state == RESP) o_rsp_valid[gidx] = 1'b1;
  end

  assign o_req_ready        = grant;
  assign o_rsp_result       = (state == RESP) ? result : '0;
  assign o_rsp_error        = (state == RESP) && error;
  assign o_mul_start        = (state == START);
  assign o_mul_multiplier   = op_a;
  assign o_mul_multiplicand = op_b;
  assign o_busy             = (state != IDLE);

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural multiplier stub.
module tb_booth_mult_arbiter;

  localparam int N = 8;
  localparam int R = 4;

  logic           clk;
  logic           rst_n;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R-1:0]   rsp_valid;
  logic [R-1:0]   rsp_ready;
  logic [2*N-1:0] rsp_result;
  logic           rsp_error;
  logic           mul_start;
  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic [2*N-1:0] mul_result;
  logic           mul_finish;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Multiplier stub: finish 2N+1 cycles after the start cycle, optionally never.
  int             mcnt;
  logic [2*N-1:0] prod;
  logic           fin;
  logic           mul_alive;
  logic           spur;

  booth_mult_arbiter #(.N(N), .R(R)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_req_valid        (req_valid),
    .o_req_ready        (req_ready),
    .i_req_a            (req_a),
    .i_req_b            (req_b),
    .o_rsp_valid        (rsp_valid),
    .i_rsp_ready        (rsp_ready),
    .o_rsp_result       (rsp_result),
    .o_rsp_error        (rsp_error),
    .o_mul_start        (mul_start),
    .o_mul_multiplier   (mul_a),
    .o_mul_multiplicand (mul_b),
    .i_mul_result       (mul_result),
    .i_mul_finish       (mul_finish),
    .o_busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 0;
      fin  <= 1'b0;
      prod <= '0;
    end else begin
      fin <= 1'b0;
      if (mul_start) begin
        mcnt <= 2 * N;
        prod <= {{N{mul_a[N-1]}}, mul_a} * {{N{mul_b[N-1]}}, mul_b};
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1 && mul_alive) fin <= 1'b1;
      end
    end
  end

  assign mul_result = spur ? 16'h1234 : prod;
  assign mul_finish = fin | spur;

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Raise valid[k], wait (bounded) for its accept pulse, then drop valid after that edge.
  task automatic issue(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                       output int acc, output logic [R-1:0] g, output bit ok);
    @(posedge clk); #1;
    req_a[k*N +: N] = a;
    req_b[k*N +: N] = b;
    req_valid[k]    = 1'b1;
    ok = 1'b0; g = '0; acc = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        ok = 1'b1; g = req_ready; acc = cyc;
      end
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_rsp(output int rc, output bit ok);
    ok = 1'b0; rc = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        ok = 1'b1; rc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_checks++;
    if ({busy, mul_start, mul_a, mul_b} !== '0) begin
      n_fail++; $display("FAIL reset_mul: busy=%b start=%b a=%h b=%h want all 0", busy, mul_start, mul_a, mul_b);
    end
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_error} !== '0) begin
      n_fail++; $display("FAIL reset_rsp: valid=%b result=%h err=%b want all 0", rsp_valid, rsp_result, rsp_error);
    end
    req_valid = '0;
    apply_reset();
  endtask

  task automatic test_single();
    int acc, rc; logic [R-1:0] g; bit ok;
    rsp_ready = '1;
    issue(0, 8'd3, 8'hFB, acc, g, ok);
    n_checks++;
    if (!ok || g !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b ok=%0d want 0001", g, ok); end
    @(negedge clk);
    n_checks++;
    if ({mul_start, mul_a, mul_b} !== {1'b1, 8'd3, 8'hFB}) begin
      n_fail++; $display("FAIL single_start: start=%b a=%h b=%h want 1 03 fb", mul_start, mul_a, mul_b);
    end
    @(negedge clk);
    n_checks++;
    if ({mul_start, mul_a, mul_b} !== {1'b0, 8'd3, 8'hFB}) begin
      n_fail++; $display("FAIL single_wait_ops: start=%b a=%h b=%h want 0 03 fb", mul_start, mul_a, mul_b);
    end
    wait_rsp(rc, ok);
    n_checks++;
    if (!ok || rc - acc != 19) begin n_fail++; $display("FAIL single_latency: got %0d ok=%0d want 19", rc - acc, ok); end
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_error} !== {4'b0001, 16'hFFF1, 1'b0}) begin
      n_fail++; $display("FAIL single_rsp: valid=%b result=%h err=%b want 0001 fff1 0", rsp_valid, rsp_result, rsp_error);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_done: valid=%b busy=%b want 0000 0", rsp_valid, busy);
    end
  endtask

  task automatic test_extreme();
    int acc, rc; logic [R-1:0] g; bit ok;
    issue(2, 8'h80, 8'h80, acc, g, ok);
    n_checks++;
    if (!ok || g !== 4'b0100) begin n_fail++; $display("FAIL extreme_grant: got %b want 0100", g); end
    wait_rsp(rc, ok);
    n_checks++;
    if (!ok || rsp_valid !== 4'b0100 || rsp_result !== 16'h4000) begin
      n_fail++; $display("FAIL extreme_min_min: valid=%b result=%h want 0100 4000", rsp_valid, rsp_result);
    end
    issue(2, 8'h7F, 8'h80, acc, g, ok);
    wait_rsp(rc, ok);
    n_checks++;
    if (!ok || rsp_result !== 16'hC080 || rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL extreme_max_min: result=%h err=%b want c080 0", rsp_result, rsp_error);
    end
  endtask

  task automatic test_backpressure();
    int acc, rc; logic [R-1:0] g; bit ok;
    rsp_ready = 4'b1101;
    issue(1, 8'h0C, 8'hF3, acc, g, ok);
    req_a[0 +: N] = 8'd1;
    req_b[0 +: N] = 8'd1;
    req_valid[0]  = 1'b1;
    wait_rsp(rc, ok);
    n_checks++;
    if (!ok || g !== 4'b0010) begin n_fail++; $display("FAIL bp_grant: got %b ok=%0d want 0010", g, ok); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      spur = (i == 3);
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_error, req_ready, mul_start, busy} !==
          {4'b0010, 16'hFF64, 1'b0, 4'b0000, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b result=%h err=%b ready=%b start=%b busy=%b want 0010 ff64 0 0000 0 1",
                 i, rsp_valid, rsp_result, rsp_error, req_ready, mul_start, busy);
      end
    end
    @(posedge clk); #1;
    spur = 1'b0;
    rsp_ready = '1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001 || rsp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL bp_release: ready=%b valid=%b want 0001 0000", req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(rc, ok);
    n_checks++;
    if (!ok || rsp_valid !== 4'b0001 || rsp_result !== 16'h0001) begin
      n_fail++; $display("FAIL bp_next: valid=%b result=%h want 0001 0001", rsp_valid, rsp_result);
    end
  endtask

  task automatic test_watchdog();
    int acc, rc; logic [R-1:0] g; bit ok;
    mul_alive = 1'b0;
    issue(3, 8'd5, 8'd5, acc, g, ok);
    wait_rsp(rc, ok);
    n_checks++;
    if (!ok || rc - acc != 22) begin n_fail++; $display("FAIL wd_latency: got %0d ok=%0d want 22", rc - acc, ok); end
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_error} !== {4'b1000, 16'h0000, 1'b1}) begin
      n_fail++; $display("FAIL wd_rsp: valid=%b result=%h err=%b want 1000 0000 1", rsp_valid, rsp_result, rsp_error);
    end
    mul_alive = 1'b1;
    issue(3, 8'd2, 8'd3, acc, g, ok);
    wait_rsp(rc, ok);
    n_checks++;
    if (!ok || rc - acc != 19 || rsp_result !== 16'h0006 || rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL wd_recover: lat=%0d result=%h err=%b want 19 0006 0", rc - acc, rsp_result, rsp_error);
    end
  endtask

  task automatic test_fairness();
    logic [R-1:0]   exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2*N-1:0] exp_r [5] = '{16'h001E, 16'hFFC1, 16'hFF38, 16'h3F01, 16'h001E};
    logic [R-1:0]   acc_g [5];
    int             acc_c [5];
    int nacc = 0;
    int nrsp = 0;
    req_a = {8'h81, 8'd100, 8'hF9, 8'd5};
    req_b = {8'h81, 8'hFE, 8'd9, 8'd6};
    rsp_ready = '1;
    apply_reset();
    req_valid = '1;
    for (int it = 0; it < 130 && nrsp < 5; it++) begin
      @(negedge clk);
      if (req_ready != '0 && nacc < 5) begin
        acc_g[nacc] = req_ready; acc_c[nacc] = cyc; nacc++;
      end
      if (rsp_valid != '0) begin
        n_checks++;
        if (rsp_valid !== exp_g[nrsp] || rsp_result !== exp_r[nrsp]) begin
          n_fail++; $display("FAIL fair_rsp[%0d]: valid=%b result=%h want %b %h", nrsp, rsp_valid, rsp_result, exp_g[nrsp], exp_r[nrsp]);
        end
        nrsp++;
      end
      @(posedge clk); #1;
      if (nacc == 5) req_valid = '0;
    end
    n_checks++;
    if (nacc != 5 || nrsp != 5) begin n_fail++; $display("FAIL fair_count: acc=%0d rsp=%0d want 5 5", nacc, nrsp); end
    for (int i = 0; i < nacc; i++) begin
      n_checks++;
      if (acc_g[i] !== exp_g[i]) begin n_fail++; $display("FAIL fair_grant[%0d]: got %b want %b", i, acc_g[i], exp_g[i]); end
      if (i > 0) begin
        n_checks++;
        if (acc_c[i] - acc_c[i-1] != 20) begin
          n_fail++; $display("FAIL fair_spacing[%0d]: got %0d want 20", i, acc_c[i] - acc_c[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int acc, rc; logic [R-1:0] g; bit ok;
    issue(1, 8'd7, 8'd3, acc, g, ok);
    repeat (5) @(posedge clk);
    #2;
    req_a[0 +: N] = 8'h0A;
    req_b[0 +: N] = 8'hF6;
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, mul_start, mul_a, mul_b, req_ready, rsp_valid, rsp_result, rsp_error} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: busy=%b start=%b a=%h b=%h ready=%b valid=%b result=%h err=%b want all 0",
               busy, mul_start, mul_a, mul_b, req_ready, rsp_valid, rsp_result, rsp_error);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_first: got %b want 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(rc, ok);
    n_checks++;
    if (!ok || rsp_valid !== 4'b0001 || rsp_result !== 16'hFF9C) begin
      n_fail++; $display("FAIL midrst_rsp: valid=%b result=%h want 0001 ff9c", rsp_valid, rsp_result);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;
    mul_alive = 1'b1;
    spur      = 1'b0;
    test_reset();
    test_single();
    test_extreme();
    test_backpressure();
    test_watchdog();
    test_fairness();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
